spi_master: RTL



---
 rtl/spi_master_pkg.sv | 23 ++
 rtl/spi_master_if.sv | 37 +++
 rtl/spi_master_sclk_tick.sv | 31 +++
 rtl/spi_master.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// spi_master_pkg -- shared definitions for the SPI master slice.
//   state_e              : frame sequencer states
//   CS_ASSERT/CS_DEASSERT: chip-select levels (active low)
//   DEF_*                : default field widths and SCLK divider
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;

    localparam int unsigned DEF_CMD_BITS     = 8;
    localparam int unsigned DEF_ADDR_BITS    = 8;
    localparam int unsigned DEF_PAYLOAD_BITS = 8;
    localparam int unsigned DEF_CLK_DIV      = 4;

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if -- request-side handshake between on-chip logic and spi_master.
//   start   : request a frame (honoured while busy=0)
//   i_frame : {cmd, addr, payload}, latched on an accepted start
//   cpol    : SCLK idle level for the frame
//   cpha    : 0 = sample on leading edge, 1 = sample on trailing edge
//   busy    : frame in progress
//   done    : one-cycle completion pulse
//   rx_data : payload captured from MISO, valid from done
// modport master: the requesting logic; modport slave: the spi_master core.
interface spi_master_if
    import spi_master_pkg::*;
#(
    parameter int unsigned CMD_BITS     = DEF_CMD_BITS,
    parameter int unsigned ADDR_BITS    = DEF_ADDR_BITS,
    parameter int unsigned PAYLOAD_BITS = DEF_PAYLOAD_BITS
);
    localparam int unsigned FRAME_BITS = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;

    logic                    start;
    logic [FRAME_BITS-1:0]   i_frame;
    logic                    cpol;
    logic                    cpha;
    logic                    busy;
    logic                    done;
    logic [PAYLOAD_BITS-1:0] rx_data;

    modport master (
        output start, i_frame, cpol, cpha,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, i_frame, cpol, cpha,
        output busy, done, rx_data
    );

endinterface

// File: rtl/spi_master_sclk_tick.sv
// spi_master_sclk_tick -- divider producing a one-cycle tick every DIV cycles.
//   sysclk : system clock
//   rst_n  : asynchronous active-low reset
//   en_i   : count while high; low holds the divider at zero so that the
//            first tick after enabling comes exactly DIV cycles later
//   tick_o : one-cycle pulse on the last cycle of each DIV-cycle period
module spi_master_sclk_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == CW'(DIV - 1));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master -- SPI master serialising a {cmd, addr, payload} frame MSB first,
// all four CPOL/CPHA modes chosen per frame, full-duplex payload capture.
//   sysclk : system clock
//   rst_n  : asynchronous active-low reset
//   req    : request handshake (spi_master_if.slave)
//   miso   : serial input from the slave
//   cs_n   : chip select, active low (registered)
//   sclk   : serial clock (registered)
//   mosi   : serial output (registered)
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned CMD_BITS     = DEF_CMD_BITS,
    parameter int unsigned ADDR_BITS    = DEF_ADDR_BITS,
    parameter int unsigned PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV
) (
    input  logic        sysclk,
    input  logic        rst_n,
    spi_master_if.slave req,
    input  logic        miso,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi
);
    localparam int unsigned FRAME_BITS = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int unsigned EDGES      = 2 * FRAME_BITS;
    localparam int unsigned EW         = $clog2(EDGES + 1);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   tx_q, tx_d;
    logic [PAYLOAD_BITS-1:0] rx_q, rx_d;
    logic [PAYLOAD_BITS-1:0] rx_data_q, rx_data_d;
    logic [EW-1:0]           edge_q, edge_d;
    logic [EW-1:0]           edge_nxt;
    logic                    cpol_q, cpol_d;
    logic                    cpha_q, cpha_d;
    logic                    cs_n_q, cs_n_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    tick;
    logic                    div_en;

    assign div_en   = (state_q != ST_IDLE);
    assign edge_nxt = edge_q + EW'(1);

    spi_master_sclk_tick #(
        .DIV (CLK_DIV)
    ) u_tick (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .en_i   (div_en),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        edge_d    = edge_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sclk_d = cpol_q;
                mosi_d = 1'b0;
                if (req.start) begin
                    state_d = ST_SETUP;
                    cpol_d  = req.cpol;
                    cpha_d  = req.cpha;
                    sclk_d  = req.cpol;
                    cs_n_d  = CS_ASSERT;
                    busy_d  = 1'b1;
                    edge_d  = '0;
                    // CPHA=0 presents the MSB together with CS; the shift
                    // register then only holds the bits still to be sent.
                    if (req.cpha) begin
                        mosi_d = 1'b0;
                        tx_d   = req.i_frame;
                    end else begin
                        mosi_d = req.i_frame[FRAME_BITS-1];
                        tx_d   = {req.i_frame[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end

            // The tick ending SETUP already produces SCLK edge 1.
            ST_SETUP, ST_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;
                    // edge_q[0]==0 means this is an odd edge; CPHA flips
                    // which parity samples and which parity shifts.
                    if (~edge_q[0] ^ cpha_q) begin
                        rx_d = {rx_q[PAYLOAD_BITS-2:0], miso};
                    end else if (edge_nxt != EW'(EDGES)) begin
                        mosi_d = tx_q[FRAME_BITS-1];
                        tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                    end
                    state_d = (edge_nxt == EW'(EDGES)) ? ST_HOLD : ST_SHIFT;
                end
            end

            ST_HOLD: begin
                if (tick) begin
                    state_d   = ST_GAP;
                    cs_n_d    = CS_DEASSERT;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                    mosi_d    = 1'b0;
                end
            end

            ST_GAP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            edge_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            cs_n_q    <= CS_DEASSERT;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            edge_q    <= edge_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cs_n        = cs_n_q;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign req.busy    = busy_q;
    assign req.done    = done_q;
    assign req.rx_data = rx_data_q;

endmodule
